top_level: RTL and testbench



---
 rtl/top_level_if.sv | 40 ++++
 rtl/top_level.sv | 131 +++++++++++++
 tb/tb_top_level.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/top_level_if.sv
// Signal bundle for the XOR block: the two operands plus the combinational
// result and all registered side-outputs. The master side drives the
// operands; the slave side is the block that produces the results.
interface top_level_if #(
   parameter int COUNT_WIDTH = 16
);
   logic                   a;
   logic                   b;
   logic                   c;
   logic                   c_q;
   logic                   c_rise;
   logic                   c_fall;
   logic                   c_stable;
   logic [COUNT_WIDTH-1:0] diff_count;
   logic [COUNT_WIDTH-1:0] toggle_count;

   modport master (
      output a,
      output b,
      input  c,
      input  c_q,
      input  c_rise,
      input  c_fall,
      input  c_stable,
      input  diff_count,
      input  toggle_count
   );

   modport slave (
      input  a,
      input  b,
      output c,
      output c_q,
      output c_rise,
      output c_fall,
      output c_stable,
      output diff_count,
      output toggle_count
   );
endinterface

// File: rtl/top_level.sv
// Two-input XOR with registered side-path: one-cycle registered copy,
// rise/fall pulse detection, debounced level and saturating statistics.
// C is purely combinational and follows A/B even while reset is held.
// The scalar port list is kept flat so that positional instantiation with
// three arguments connects A, B and C.
module top_level #(
   parameter int COUNT_WIDTH     = 16,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                   A,
   input  logic                   B,
   output logic                   C,
   input  logic                   clock,
   input  logic                   reset_n,
   output logic                   c_q,
   output logic                   c_rise,
   output logic                   c_fall,
   output logic                   c_stable,
   output logic [COUNT_WIDTH-1:0] diff_count,
   output logic [COUNT_WIDTH-1:0] toggle_count
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1 before the
   // level flips, so clog2(DEBOUNCE_CYCLES) bits suffice (min 1 bit).
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]        DB_ZERO = {DB_W{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   logic                   rst_release_r;
   logic                   c_q_r;
   logic                   c_q_prev_r;
   logic                   c_rise_r;
   logic                   c_fall_r;
   logic                   c_stable_r;
   logic [DB_W-1:0]        db_cnt_r;
   logic [COUNT_WIDTH-1:0] diff_count_r;
   logic [COUNT_WIDTH-1:0] toggle_count_r;

   logic                   c_s;
   logic                   c_stable_s;
   logic [DB_W-1:0]        db_cnt_s;
   logic [COUNT_WIDTH-1:0] diff_next_s;
   logic [COUNT_WIDTH-1:0] toggle_next_s;

   assign c_s = A ^ B;
   assign C   = c_s;

   // Retime reset release: asserts immediately, releases on the first edge
   // so the state registers start updating on the second edge after release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_release_r <= 1'b0;
      end else begin
         rst_release_r <= 1'b1;
      end
   end

   // Debounce: count consecutive samples that disagree with the stable level.
   always_comb begin
      db_cnt_s   = db_cnt_r;
      c_stable_s = c_stable_r;
      if (c_s != c_stable_r) begin
         if (db_cnt_r == DB_LAST) begin
            c_stable_s = c_s;
            db_cnt_s   = DB_ZERO;
         end else begin
            db_cnt_s   = db_cnt_r + DB_W'(1);
         end
      end else begin
         db_cnt_s = DB_ZERO;
      end
   end

   // Saturating statistics: cycles with C high and c_q transitions.
   always_comb begin
      diff_next_s   = diff_count_r;
      toggle_next_s = toggle_count_r;
      if (c_s && (diff_count_r != CNT_MAX)) begin
         diff_next_s = diff_count_r + CNT_ONE;
      end else begin
         diff_next_s = diff_count_r;
      end
      if ((c_rise_r || c_fall_r) && (toggle_count_r != CNT_MAX)) begin
         toggle_next_s = toggle_count_r + CNT_ONE;
      end else begin
         toggle_next_s = toggle_count_r;
      end
   end

   // Side-path state: clears asynchronously, holds until reset release is retimed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         c_q_r          <= 1'b0;
         c_q_prev_r     <= 1'b0;
         c_rise_r       <= 1'b0;
         c_fall_r       <= 1'b0;
         c_stable_r     <= 1'b0;
         db_cnt_r       <= DB_ZERO;
         diff_count_r   <= {COUNT_WIDTH{1'b0}};
         toggle_count_r <= {COUNT_WIDTH{1'b0}};
      end else if (!rst_release_r) begin
         c_q_r          <= 1'b0;
         c_q_prev_r     <= 1'b0;
         c_rise_r       <= 1'b0;
         c_fall_r       <= 1'b0;
         c_stable_r     <= 1'b0;
         db_cnt_r       <= DB_ZERO;
         diff_count_r   <= {COUNT_WIDTH{1'b0}};
         toggle_count_r <= {COUNT_WIDTH{1'b0}};
      end else begin
         c_q_r          <= c_s;
         c_q_prev_r     <= c_q_r;
         c_rise_r       <= c_q_r & ~c_q_prev_r;
         c_fall_r       <= ~c_q_r & c_q_prev_r;
         c_stable_r     <= c_stable_s;
         db_cnt_r       <= db_cnt_s;
         diff_count_r   <= diff_next_s;
         toggle_count_r <= toggle_next_s;
      end
   end

   assign c_q          = c_q_r;
   assign c_rise       = c_rise_r;
   assign c_fall       = c_fall_r;
   assign c_stable     = c_stable_r;
   assign diff_count   = diff_count_r;
   assign toggle_count = toggle_count_r;

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level with COUNT_WIDTH=4, DEBOUNCE_CYCLES=4.
// Expected values are hand-derived edge by edge in the step comments.
module tb_top_level;

   localparam int CW = 4;

   logic clock;
   logic reset_n;
   logic clk_en;
   int   checks;
   int   errors;

   top_level_if #(.COUNT_WIDTH(CW)) bus ();

   top_level #(
      .COUNT_WIDTH     (CW),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .A            (bus.a),
      .B            (bus.b),
      .C            (bus.c),
      .clock        (clock),
      .reset_n      (reset_n),
      .c_q          (bus.c_q),
      .c_rise       (bus.c_rise),
      .c_fall       (bus.c_fall),
      .c_stable     (bus.c_stable),
      .diff_count   (bus.diff_count),
      .toggle_count (bus.toggle_count)
   );

   // Clock toggles only while enabled so the combinational sweep sees an idle clock.
   always begin
      #5;
      if (clk_en) clock = ~clock;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      clk_en  = 1'b0;
      clock   = 1'b0;
      reset_n = 1'b1;
      bus.a   = 1'b0;
      bus.b   = 1'b0;
      #1;
      reset_n = 1'b0;

      // Combinational sweep, clock idle, reset held
      bus.a = 1'b0; bus.b = 1'b0; #1; chk1("xor_00", bus.c, 1'b0);
      bus.a = 1'b0; bus.b = 1'b1; #1; chk1("xor_01", bus.c, 1'b1);
      bus.a = 1'b1; bus.b = 1'b1; #1; chk1("xor_11", bus.c, 1'b0);
      bus.a = 1'b1; bus.b = 1'b0; #1; chk1("xor_10", bus.c, 1'b1);

      // Reset values with A=1,B=0
      chk1("rst_c_q",      bus.c_q,      1'b0);
      chk1("rst_c_rise",   bus.c_rise,   1'b0);
      chk1("rst_c_fall",   bus.c_fall,   1'b0);
      chk1("rst_c_stable", bus.c_stable, 1'b0);
      chkc("rst_diff",     bus.diff_count,   4'd0);
      chkc("rst_toggle",   bus.toggle_count, 4'd0);

      // Clock running under reset: still held, C still follows inputs
      clk_en = 1'b1;
      tick(); tick();
      chk1("rst_clk_c_q", bus.c_q, 1'b0);
      chk1("rst_clk_c",   bus.c,   1'b1);

      // Release between edges: c_q captures on the second edge
      reset_n = 1'b1;
      tick();
      chk1("rel_e1_c_q", bus.c_q, 1'b0);
      tick();
      chk1("rel_e2_c_q", bus.c_q, 1'b1);
      chkc("rel_e2_diff", bus.diff_count, 4'd1);

      // Asynchronous clear of c_q, then clean release with C=0
      #2;
      reset_n = 1'b0;
      #1;
      chk1("async_c_q", bus.c_q, 1'b0);
      bus.a = 1'b0; bus.b = 1'b0;
      tick();
      reset_n = 1'b1;
      tick(); tick();
      chk1("clean_c_q", bus.c_q, 1'b0);

      // Edge detect: C high for 3 samples then low (also short debounce burst)
      bus.a = 1'b1;
      tick();                                    // e1
      chk1("e1_c_q",    bus.c_q,    1'b1);
      chk1("e1_c_rise", bus.c_rise, 1'b0);
      tick();                                    // e2
      chk1("e2_c_rise", bus.c_rise, 1'b1);
      chk1("e2_c_fall", bus.c_fall, 1'b0);
      tick();                                    // e3
      chk1("e3_c_rise",   bus.c_rise,       1'b0);
      chkc("e3_toggle",   bus.toggle_count, 4'd1);
      chkc("e3_diff",     bus.diff_count,   4'd3);
      chk1("e3_c_stable", bus.c_stable,     1'b0);
      bus.a = 1'b0;
      tick();                                    // e4
      chk1("e4_c_q",      bus.c_q,      1'b0);
      chk1("e4_c_fall",   bus.c_fall,   1'b0);
      chk1("e4_c_stable", bus.c_stable, 1'b0);
      tick();                                    // e5
      chk1("e5_c_fall", bus.c_fall, 1'b1);
      chk1("e5_c_rise", bus.c_rise, 1'b0);
      tick();                                    // e6
      chk1("e6_c_fall",   bus.c_fall,       1'b0);
      chkc("e6_toggle",   bus.toggle_count, 4'd2);
      chk1("e6_c_stable", bus.c_stable,     1'b0);
      chkc("e6_diff",     bus.diff_count,   4'd3);

      // Debounce: C high, c_stable flips on the 4th sample
      bus.a = 1'b1;
      tick();                                    // f1
      tick();                                    // f2
      chk1("f2_c_rise", bus.c_rise, 1'b1);
      tick();                                    // f3
      chk1("f3_c_stable", bus.c_stable,     1'b0);
      chkc("f3_toggle",   bus.toggle_count, 4'd3);
      tick();                                    // f4
      chk1("f4_c_stable", bus.c_stable,   1'b1);
      chkc("f4_diff",     bus.diff_count, 4'd7);

      // Asynchronous reset between edges with diff_count=7
      #2;
      reset_n = 1'b0;
      #1;
      chkc("mid_diff",     bus.diff_count,   4'd0);
      chkc("mid_toggle",   bus.toggle_count, 4'd0);
      chk1("mid_c_stable", bus.c_stable,     1'b0);
      chk1("mid_c_rise",   bus.c_rise,       1'b0);

      // Saturation: A!=B held; counting resumes on second edge after release
      bus.a = 1'b1; bus.b = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();                                    // g1
      chk1("g1_c_q",  bus.c_q,        1'b0);
      chkc("g1_diff", bus.diff_count, 4'd0);
      tick();                                    // g2
      chk1("g2_c_q",  bus.c_q,        1'b1);
      chkc("g2_diff", bus.diff_count, 4'd1);
      chk1("g2_c_rise", bus.c_rise,   1'b0);
      repeat (14) tick();                        // g16
      chkc("sat_reach", bus.diff_count, 4'd15);
      repeat (5) tick();                         // g21
      chkc("sat_hold",  bus.diff_count,   4'd15);
      chkc("sat_toggle", bus.toggle_count, 4'd1);
      chk1("sat_c_stable", bus.c_stable,   1'b1);
      chk1("sat_c_rise",   bus.c_rise,     1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
